udp_loopback: RTL

UDP_LOOPBACK -- requirements
Module: udp_loopback

---
 rtl/udp_loopback.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/udp_loopback.sv
// UDP payload loopback: buffers one received datagram and echoes it back unchanged.
// Datagrams that arrive while a frame is waiting or being sent are discarded and counted.
module udp_loopback #(
    parameter int unsigned BUF_DEPTH = 2048,
    parameter int unsigned ADDR_W    = 11
) (
    input  logic        gmii_rx_clk,
    input  logic        rst_n,
    input  logic        udp_rx_data_vld,
    input  logic [7:0]  udp_rx_data,
    input  logic        udp_rx_done,
    input  logic        tx_rdy,
    input  logic        udp_tx_req,
    output logic        udp_tx_en,
    output logic [7:0]  udp_tx_data,
    output logic [15:0] udp_tx_data_num,
    output logic        busy,
    output logic [15:0] drop_cnt
);
    typedef enum logic [1:0] {StIdle, StRecv, StWaitRdy, StSend} state_e;

    localparam logic [15:0] Depth = 16'(BUF_DEPTH);

    state_e      state_q, state_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] num_q, num_d;
    logic [15:0] drop_q, drop_d;
    logic        ovf_q, ovf_d;
    logic        ign_q, ign_d;
    logic        rd_vld_q, rd_vld_d;
    logic        wr_en, rd_en, capture, ovf_now, drop_inc;
    logic [15:0] cnt_now;
    logic [7:0]  rd_data_q;
    logic [7:0]  mem [BUF_DEPTH];

    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        num_d     = num_q;
        drop_d    = drop_q;
        ovf_d     = ovf_q;
        ign_d     = ign_q;
        rd_vld_d  = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        ovf_now   = ovf_q;
        cnt_now   = wr_cnt_q;
        drop_inc  = 1'b0;
        udp_tx_en = 1'b0;
        capture   = (state_q == StRecv) ||
                    ((state_q == StIdle) && udp_rx_data_vld && !ign_q);

        unique case (state_q)
            StIdle, StRecv: begin
                if (capture) begin
                    state_d = StRecv;
                    // The byte of this cycle is counted before any done in the same cycle.
                    if (udp_rx_data_vld) begin
                        if (wr_cnt_q < Depth) begin
                            wr_en   = 1'b1;
                            cnt_now = wr_cnt_q + 16'd1;
                        end else begin
                            ovf_now = 1'b1;
                        end
                    end
                    if (udp_rx_done) begin
                        state_d  = ovf_now ? StIdle : StWaitRdy;
                        drop_inc = ovf_now;
                        if (!ovf_now) begin
                            num_d = cnt_now;
                        end
                        wr_cnt_d = '0;
                        ovf_d    = 1'b0;
                    end else begin
                        wr_cnt_d = cnt_now;
                        ovf_d    = ovf_now;
                    end
                end
            end
            StWaitRdy: begin
                if (tx_rdy) begin
                    udp_tx_en = 1'b1;
                    state_d   = StSend;
                    rd_cnt_d  = '0;
                end
            end
            StSend: begin
                if (rd_cnt_q >= num_q) begin
                    state_d  = StIdle;
                    rd_cnt_d = '0;
                end else if (udp_tx_req) begin
                    rd_en    = 1'b1;
                    rd_vld_d = 1'b1;
                    rd_cnt_d = rd_cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A datagram starting while the buffer is occupied is swallowed up to its done pulse.
        if (ign_q || (udp_rx_data_vld && ((state_q == StWaitRdy) || (state_q == StSend)))) begin
            ign_d    = !udp_rx_done;
            drop_inc = drop_inc | udp_rx_done;
        end

        if (drop_inc && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            num_q    <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
            ign_q    <= 1'b0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            num_q    <= num_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
            ign_q    <= ign_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    always_ff @(posedge gmii_rx_clk) begin
        if (wr_en) begin
            mem[wr_cnt_q[ADDR_W-1:0]] <= udp_rx_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_cnt_q[ADDR_W-1:0]];
        end
    end

    assign udp_tx_data     = rd_vld_q ? rd_data_q : 8'h00;
    assign udp_tx_data_num = num_q;
    assign busy            = (state_q != StIdle);
    assign drop_cnt        = drop_q;

endmodule
